// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter -- writeback arbiter for the single register-file write port.
//
// Merges the single-cycle ALU result stream and the long-latency MDU result
// stream into one registered write port. MDU results that cannot be written
// immediately wait in a small FIFO. A starvation counter throttles the ALU so
// that queued MDU results always drain. Decode gets per-operand hazard flags
// for every register write that has not yet reached the register file.
//
// Ports:
//   clk                       rising-edge clock
//   rst                       synchronous, active-low reset (0 = reset)
//   alu_valid/alu_ready       ALU result handshake, alu_rd / alu_data payload
//   mdu_valid/mdu_ready       MDU result handshake, mdu_rd / mdu_data payload
//   q_rs1, q_rs2, q_rd        decode query registers
//   hit_rs1, hit_rs2, hit_rd  query matches a pending write (combinational)
//   wEn, rd, write_data       registered register-file write port
//
// Handshake: a producer raises valid with a stable payload and keeps both
// stable until it sees valid && ready at a rising edge; the transfer happens
// at exactly that edge. ready never depends on the same-cycle valid.
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    input  logic [4:0]  q_rs1,
    input  logic [4:0]  q_rs2,
    input  logic [4:0]  q_rd,
    output logic        hit_rs1,
    output logic        hit_rs2,
    output logic        hit_rd,
    output logic        wEn,
    output logic [4:0]  rd,
    output logic [31:0] write_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]    fifo_rd   [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_next;
    logic          throttle;

    logic fifo_empty;
    logic sel_alu;
    logic sel_pop;
    logic sel_byp;
    logic push;

    assign fifo_empty = (count == '0);
    // Depends on count only, so a full FIFO refuses even in a popping cycle.
    assign mdu_ready  = (count < CW'(DEPTH));
    assign alu_ready  = ~throttle;

    // Fixed-priority winner selection for the output register.
    always_comb begin
        sel_alu = 1'b0;
        sel_pop = 1'b0;
        sel_byp = 1'b0;
        if (throttle && !fifo_empty) begin
            sel_pop = 1'b1;
        end else if (alu_valid && alu_ready && (alu_rd != 5'd0)) begin
            sel_alu = 1'b1;
        end else if (!fifo_empty) begin
            sel_pop = 1'b1;
        end else if (mdu_valid && (mdu_rd != 5'd0)) begin
            // FIFO is empty here, so mdu_ready is 1 and the result is accepted.
            sel_byp = 1'b1;
        end
    end

    // rd=0 MDU results are accepted and dropped; bypassed ones are not queued.
    assign push = mdu_valid && mdu_ready && (mdu_rd != 5'd0) && !sel_byp;

    always_comb begin
        if (fifo_empty || sel_pop) begin
            starve_next = '0;
        end else if (starve_cnt < SW'(STARVE_MAX)) begin
            starve_next = starve_cnt + 1'b1;
        end else begin
            starve_next = starve_cnt;
        end
    end

    // Hazard flags: every queued entry plus the output register, which has
    // not reached the register file during its wEn cycle.
    always_comb begin
        logic [AW-1:0] idx;
        idx     = rd_ptr;
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        hit_rd  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + AW'(k);
            if (CW'(k) < count) begin
                if (fifo_rd[idx] == q_rs1) hit_rs1 = 1'b1;
                if (fifo_rd[idx] == q_rs2) hit_rs2 = 1'b1;
                if (fifo_rd[idx] == q_rd)  hit_rd  = 1'b1;
            end
        end
        if (wEn && (rd == q_rs1)) hit_rs1 = 1'b1;
        if (wEn && (rd == q_rs2)) hit_rs2 = 1'b1;
        if (wEn && (rd == q_rd))  hit_rd  = 1'b1;
        if (q_rs1 == 5'd0) hit_rs1 = 1'b0;
        if (q_rs2 == 5'd0) hit_rs2 = 1'b0;
        if (q_rd  == 5'd0) hit_rd  = 1'b0;
    end

    // FIFO storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            fifo_rd[wr_ptr]   <= mdu_rd;
            fifo_data[wr_ptr] <= mdu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            throttle   <= 1'b0;
            wEn        <= 1'b0;
            rd         <= 5'd0;
            write_data <= 32'd0;
        end else begin
            starve_cnt <= starve_next;
            // Clear one edge after the FIFO has drained; set on reaching limit.
            if (throttle && fifo_empty) begin
                throttle <= 1'b0;
            end else if (starve_next == SW'(STARVE_MAX)) begin
                throttle <= 1'b1;
            end

            if (push)    wr_ptr <= wr_ptr + 1'b1;
            if (sel_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, sel_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            wEn <= sel_alu | sel_pop | sel_byp;
            if (sel_alu) begin
                rd         <= alu_rd;
                write_data <= alu_data;
            end else if (sel_pop) begin
                rd         <= fifo_rd[rd_ptr];
                write_data <= fifo_data[rd_ptr];
            end else if (sel_byp) begin
                rd         <= mdu_rd;
                write_data <= mdu_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter -- directed bench for wb_arbiter.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// A negedge monitor compares every write-port pulse against exp_q, which the
// tests preload with the hand-derived write order.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic [4:0]  q_rd;
    logic        hit_rs1;
    logic        hit_rs2;
    logic        hit_rd;
    logic        wEn;
    logic [4:0]  rd;
    logic [31:0] write_data;

    logic [36:0] exp_q[$];
    logic [36:0] mon_exp;
    int          n_cmp = 0;
    int          n_err = 0;

    wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mdu_valid  (mdu_valid),
        .mdu_ready  (mdu_ready),
        .mdu_rd     (mdu_rd),
        .mdu_data   (mdu_data),
        .q_rs1      (q_rs1),
        .q_rs2      (q_rs2),
        .q_rd       (q_rd),
        .hit_rs1    (hit_rs1),
        .hit_rs2    (hit_rs2),
        .hit_rd     (hit_rd),
        .wEn        (wEn),
        .rd         (rd),
        .write_data (write_data)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_rd    = 5'd0;
        alu_data  = 32'd0;
        mdu_valid = 1'b0;
        mdu_rd    = 5'd0;
        mdu_data  = 32'd0;
    endtask

    task automatic exp_write(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back({r, d});
    endtask

    // Continuous ALU stream (rd 16..22) plus three MDU results (rd 8..10).
    // Producers advance only when their handshake completes at the edge.
    task automatic run_stream(input int ncyc);
        int   ai;
        int   mi;
        logic fa;
        logic fm;
        ai = 0;
        mi = 0;
        for (int n = 0; n < ncyc; n++) begin
            alu_valid = (ai < 7);
            alu_rd    = 5'(16 + ai);
            alu_data  = 32'hA000_0000 | 32'(ai);
            mdu_valid = (mi < 3);
            mdu_rd    = 5'(8 + mi);
            mdu_data  = 32'hB000_0000 | 32'(mi);
            fa = alu_valid && alu_ready;
            fm = mdu_valid && mdu_ready;
            step();
            if (fa) ai++;
            if (fm) mi++;
            if (n == 1) check_eq("full_mdu_ready", 64'(mdu_ready), 64'd0);
            if (n == 3) check_eq("pre_throttle_alu_ready", 64'(alu_ready), 64'd1);
            if (n == 4) check_eq("throttle_alu_ready", 64'(alu_ready), 64'd0);
            if (n == 5) check_eq("first_pop_rd", 64'({wEn, rd}), 64'({1'b1, 5'd8}));
            if (n == 7) begin
                check_eq("third_mdu_rd", 64'({wEn, rd}), 64'({1'b1, 5'd10}));
                check_eq("drained_still_throttled", 64'(alu_ready), 64'd0);
            end
            if (n == 8) begin
                check_eq("gap_wen", 64'(wEn), 64'd0);
                check_eq("throttle_release", 64'(alu_ready), 64'd1);
            end
        end
        idle_inputs();
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (wEn) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 64'({1'b1, rd, write_data}), 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("write_order", 64'({rd, write_data}), 64'(mon_exp));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // 1. reset with all valids high
        rst       = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd1;
        alu_data  = 32'h1111_1111;
        mdu_valid = 1'b1;
        mdu_rd    = 5'd2;
        mdu_data  = 32'h2222_2222;
        q_rs1     = 5'd0;
        q_rs2     = 5'd0;
        q_rd      = 5'd0;
        step();
        step();
        check_eq("rst_wen", 64'(wEn), 64'd0);
        check_eq("rst_rd", 64'(rd), 64'd0);
        check_eq("rst_data", 64'(write_data), 64'd0);
        check_eq("rst_mdu_ready", 64'(mdu_ready), 64'd1);
        check_eq("rst_alu_ready", 64'(alu_ready), 64'd1);
        rst = 1'b1;
        idle_inputs();
        step();
        check_eq("post_rst_wen", 64'(wEn), 64'd0);

        // 2. single ALU write
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEAD_BEEF;
        exp_write(5'd5, 32'hDEAD_BEEF);
        step();
        idle_inputs();
        check_eq("alu_wen", 64'(wEn), 64'd1);
        check_eq("alu_rd", 64'(rd), 64'd5);
        check_eq("alu_data", 64'(write_data), 64'hDEAD_BEEF);
        step();
        check_eq("alu_wen_drop", 64'(wEn), 64'd0);
        check_eq("alu_rd_hold", 64'(rd), 64'd5);

        // 3a. MDU bypass
        mdu_valid = 1'b1;
        mdu_rd    = 5'd7;
        mdu_data  = 32'h12;
        exp_write(5'd7, 32'h12);
        step();
        idle_inputs();
        check_eq("byp_write", 64'({wEn, rd, write_data}), 64'({1'b1, 5'd7, 32'h12}));
        q_rs1 = 5'd7;
        #1;
        check_eq("byp_hit_outreg", 64'(hit_rs1), 64'd1);
        step();
        check_eq("byp_wen_drop", 64'(wEn), 64'd0);
        check_eq("byp_hit_gone", 64'(hit_rs1), 64'd0);

        // 3b. concurrent ALU and MDU: ALU first, MDU queued then written
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'h33;
        mdu_valid = 1'b1;
        mdu_rd    = 5'd7;
        mdu_data  = 32'h12;
        exp_write(5'd3, 32'h33);
        exp_write(5'd7, 32'h12);
        step();
        idle_inputs();
        check_eq("conc_alu_first", 64'({wEn, rd, write_data}), 64'({1'b1, 5'd3, 32'h33}));
        q_rs1 = 5'd7;
        q_rs2 = 5'd3;
        q_rd  = 5'd9;
        #1;
        check_eq("queued_hit_rs1", 64'(hit_rs1), 64'd1);
        check_eq("outreg_hit_rs2", 64'(hit_rs2), 64'd1);
        check_eq("no_hit_rd", 64'(hit_rd), 64'd0);
        step();
        check_eq("conc_mdu_second", 64'({wEn, rd, write_data}), 64'({1'b1, 5'd7, 32'h12}));
        step();
        check_eq("conc_done_wen", 64'(wEn), 64'd0);
        check_eq("conc_done_hit", 64'(hit_rs1), 64'd0);
        q_rs1 = 5'd0;
        q_rs2 = 5'd0;
        q_rd  = 5'd0;

        // 4. full FIFO, starvation throttle, in-order drain
        for (int k = 0; k < 5; k++) exp_write(5'(16 + k), 32'hA000_0000 | 32'(k));
        exp_write(5'd8,  32'hB000_0000);
        exp_write(5'd9,  32'hB000_0001);
        exp_write(5'd10, 32'hB000_0002);
        exp_write(5'd21, 32'hA000_0005);
        exp_write(5'd22, 32'hA000_0006);
        run_stream(12);
        step();
        check_eq("stream_drained", 64'(exp_q.size()), 64'd0);

        // 5. rd=0 results are consumed without a write or a push
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 32'hFFFF_FFFF;
        mdu_valid = 1'b1;
        mdu_rd    = 5'd0;
        mdu_data  = 32'hFFFF_FFFF;
        q_rs1     = 5'd0;
        #1;
        check_eq("rd0_hit_rs1", 64'(hit_rs1), 64'd0);
        step();
        check_eq("rd0_wen_1", 64'(wEn), 64'd0);
        step();
        check_eq("rd0_wen_2", 64'(wEn), 64'd0);
        check_eq("rd0_fifo_empty", 64'(mdu_ready), 64'd1);
        check_eq("rd0_alu_ready", 64'(alu_ready), 64'd1);
        idle_inputs();
        step();

        // 6. reset mid-operation with two entries queued and throttle set
        for (int k = 0; k < 5; k++) exp_write(5'(16 + k), 32'hA000_0000 | 32'(k));
        run_stream(5);
        rst = 1'b0;
        step();
        check_eq("midrst_wen", 64'(wEn), 64'd0);
        check_eq("midrst_alu_ready", 64'(alu_ready), 64'd1);
        check_eq("midrst_mdu_ready", 64'(mdu_ready), 64'd1);
        q_rs1 = 5'd8;
        #1;
        check_eq("midrst_no_hit", 64'(hit_rs1), 64'd0);
        rst = 1'b1;
        step();
        step();
        step();
        check_eq("midrst_no_stale", 64'(wEn), 64'd0);
        check_eq("final_queue_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
